rr_output_arbiter: RTL and testbench
====================================

Name: rr_output_arbiter

Overview:
- Round-robin output-port arbiter for one NoC router output.
- Shares a single PL-bit output link between REN input buffers.
- Issues a one-cycle pop strobe to the winning buffer and registers the winning packet onto the link.
- Replaces fixed-priority selection with fair rotation and adds downstream flow control.

Parameters:
REN, 5, number of requesting input ports (1..16)
PL, 8, packet width in bits
CRED_MAX, 4, downstream buffer depth in packets (credit mode only; 1..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_data  input  REN*PL  packed packets; port i occupies bits [i*PL +: PL]
in_valid  input  REN  port i holds a packet; payload value irrelevant (all-zero payload legal)
in_ready  output  REN  one-hot pop strobe; pulses 1 cycle when port i's packet is accepted
out_data  output  PL  registered packet to link
out_valid  output  1  out_data holds a packet
out_ready  input  1  downstream accepts (handshake mode only; ignored in credit mode)
credit_in  input  1  downstream freed one slot (credit mode only; ignored otherwise)
grant_idx  output  4  index of last granted port
cred_err  output  1  sticky; credit overflow seen (credit mode only, else 0)

Behaviour:
- Reset values: out_data=0, out_valid=0, in_ready=0, grant_idx=0, ptr=0, cred_err=0, credit count=CRED_MAX.
- Pointer ptr is the highest-priority port. Search order: ptr, ptr+1, ..., wrapping mod REN.
- Arbitration is combinational on in_valid in cycle t. The grant fires if can_load.
  - On grant to port i: in_ready[i]=1 in cycle t (same cycle).
  - At edge t+1: out_data<=packet i, out_valid<=1, grant_idx<=i, ptr<=(i+1) mod REN.
  - Latency request to out_valid is 1 cycle. Throughput is 1 packet/cycle.
- No grant when no in_valid is set: ptr and grant_idx hold, in_ready=0.
- in_ready is never set for a port with in_valid=0. At most one in_ready bit is set per cycle.
- Handshake mode (no macro):
  - can_load = !out_valid | out_ready.
  - Transfer occurs when out_valid & out_ready.
  - If a transfer occurs with no new grant: out_valid<=0, out_data holds its value.
  - If out_valid=1 and out_ready=0: out_data and out_valid hold stable, no grant.
- Wrap-around: a grant to port REN-1 sets ptr=0.
- A port re-requesting after its grant gets lowest priority while any other port requests.
- Starvation bound: a continuously valid port is granted within REN grants.
- rst mid-operation:
  - The in-flight out_data packet is dropped and out_valid goes to 0 at that edge.
  - in_ready=0 during any cycle rst=1.
- REN=1: always grant port 0 when valid and can_load. ptr stays 0.

Optional Feature:
- Macro: ARB_CREDIT_EN.
- Defined (credit mode):
  - Counter cnt, width 4, reset to CRED_MAX.
  - can_load = (cnt != 0).
  - out_valid is a 1-cycle pulse per granted packet; out_ready is ignored.
  - Each edge: cnt <= cnt - grant + credit_in. A simultaneous grant and credit leaves cnt unchanged.
  - credit_in arriving while cnt==CRED_MAX with no grant: cnt holds and cred_err<=1 (sticky until rst).
  - A credit_in in cycle t is usable for grants from cycle t+1.
- Undefined: valid/ready handshake as above. cred_err tied 0, credit_in unused, no counter logic.

Test Plan:
1. REN=5, PL=8, after rst: in_valid=5'b00101, data[0]=8'hFF, data[2]=8'hAA, out_ready=1.
   -> cycle0: in_ready=00001; next out_data=FF, grant_idx=0. Next cycle: in_ready=00100, out_data=AA, grant_idx=2, ptr=3.
2. All 5 valid, data 10,20,80,40,50, held continuously with out_ready=1.
   -> out_data sequence 10,20,80,40,50,10 on consecutive cycles; grant_idx 0,1,2,3,4,0.
3. Port 3 only valid (FF) with out_ready=0 for 3 cycles.
   -> out_data=FF, out_valid=1 held stable; in_ready=0 during the stall. Release: transfer, out_valid=0 next cycle (port 3 deasserted).
4. All inputs invalid for 4 cycles after traffic.
   -> out_valid=0, no in_ready pulses, no phantom packet, grant_idx unchanged.
5. rst asserted while out_valid=1 with data 80 and ports 1,4 valid.
   -> next edge: out_valid=0, ptr=0; in_ready=0 while rst=1. After release, port 1 granted first.
6. ARB_CREDIT_EN, CRED_MAX=4, all ports valid, credit_in=0.
   -> exactly 4 grants then stall. One credit_in pulse yields exactly one more grant next cycle. credit_in at cnt=4 with all inputs invalid sets cred_err=1.

Source files
------------

// File: rtl/rr_output_arbiter.sv
// rr_output_arbiter: round-robin arbiter driving one registered router output link; `ARB_CREDIT_EN selects credit flow control over valid/ready.
module rr_output_arbiter #(
  parameter int REN = 5,
  parameter int PL = 8,
  parameter int CRED_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REN*PL-1:0] in_data,
  input  logic [REN-1:0]    in_valid,
  output logic [REN-1:0]    in_ready,
  output logic [PL-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              credit_in,
  output logic [3:0]        grant_idx,
  output logic              cred_err
);
  logic [3:0] ptr, win, nxt, idx;
  logic [15:0] vpad;
  logic [PL-1:0] pkt;
  logic found, can_load, grant, hold;
  assign vpad = 16'(in_valid);
  // Scan from the far end back towards ptr so the closest requester wins.
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = REN - 1; k >= 0; k--) begin
      idx = 4'((int'(ptr) + k) % REN);
      if (vpad[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    pkt = '0;
    in_ready = '0;
    for (int i = 0; i < REN; i++) begin
      pkt = (win == 4'(i)) ? in_data[i*PL +: PL] : pkt;
      in_ready[i] = grant && (win == 4'(i));
    end
  end
  assign nxt = (win == 4'(REN - 1)) ? 4'd0 : win + 4'd1;
  assign grant = found & can_load & ~rst;
`ifdef ARB_CREDIT_EN
  logic [3:0] cnt;
  logic unused_ready;
  assign unused_ready = out_ready;
  assign can_load = cnt != 4'd0;
  assign hold = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'(CRED_MAX);
      cred_err <= 1'b0;
    end else if (credit_in && !grant && cnt == 4'(CRED_MAX)) begin
      cred_err <= 1'b1;
    end else begin
      cnt <= cnt + 4'(credit_in) - 4'(grant);
    end
  end
`else
  logic unused_credit;
  assign unused_credit = credit_in;
  assign can_load = !out_valid | out_ready;
  assign hold = out_valid & ~out_ready;
  assign cred_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_valid <= 1'b0;
      grant_idx <= '0;
      ptr <= '0;
    end else begin
      out_valid <= grant | hold;
      if (grant) begin
        out_data <= pkt;
        grant_idx <= win;
        ptr <= nxt;
      end
    end
  end
endmodule

// File: tb/tb_rr_output_arbiter.sv
// tb_rr_output_arbiter: directed scoreboard bench for rr_output_arbiter.
module tb_rr_output_arbiter;
  localparam int REN = 5, PL = 8, CRED_MAX = 4;
  logic clk = 1'b0, rst, out_ready, credit_in, out_valid, cred_err;
  logic [REN*PL-1:0] in_data;
  logic [REN-1:0] in_valid, in_ready;
  logic [PL-1:0] out_data;
  logic [3:0] grant_idx;
  logic [11:0] sb[$];
  logic [11:0] exp_pkt;
  int n_chk = 0, n_fail = 0;

  rr_output_arbiter #(.REN(REN), .PL(PL), .CRED_MAX(CRED_MAX)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .credit_in(credit_in), .grant_idx(grant_idx), .cred_err(cred_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input int i, input logic [PL-1:0] v);
    in_data[i*PL +: PL] = v;
  endtask

  task automatic ready_at_neg(input string nm, input logic [REN-1:0] exp);
    @(negedge clk);
    chk(nm, 32'(in_ready), 32'(exp));
  endtask

  // Monitor: every packet delivered to the link is popped and compared as {grant_idx, out_data}.
  always @(negedge clk) begin
`ifdef ARB_CREDIT_EN
    if (!rst && out_valid) begin
`else
    if (!rst && out_valid && out_ready) begin
`endif
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL phantom_pkt: got idx %0d data %0h expected none", grant_idx, out_data);
      end else begin
        exp_pkt = sb.pop_front();
        chk("sb_pkt", 32'({grant_idx, out_data}), 32'(exp_pkt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1; credit_in = 1'b0;
    cyc(); cyc();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_grant_idx", 32'(grant_idx), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_cred_err", 32'(cred_err), 0);
    rst = 1'b0;
`ifdef ARB_CREDIT_EN
    for (int i = 0; i < REN; i++) setd(i, 8'(8'h10 * (i + 1)));
    in_valid = '1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({4'(i), 8'(8'h10 * (i + 1))});
      ready_at_neg("cr_grant", 5'(1 << i));
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      ready_at_neg("cr_stall", 5'b0);
      cyc();
    end
    credit_in = 1'b1;
    ready_at_neg("cr_credit_cycle", 5'b0);
    cyc();
    credit_in = 1'b0;
    sb.push_back({4'd4, 8'h50});
    ready_at_neg("cr_extra_grant", 5'b10000);
    cyc();
    ready_at_neg("cr_stall_again", 5'b0);
    cyc();
    in_valid = '0;
    credit_in = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("cr_err_before", 32'(cred_err), 0);
    cyc();
    credit_in = 1'b0;
    chk("cr_err_set", 32'(cred_err), 1);
    cyc();
    chk("cr_err_sticky", 32'(cred_err), 1);
`else
    // Two requesters from ptr=0.
    setd(0, 8'hFF); setd(2, 8'hAA); in_valid = 5'b00101;
    sb.push_back({4'd0, 8'hFF});
    ready_at_neg("t1_first", 5'b00001);
    cyc();
    chk("t1_data0", 32'(out_data), 32'h FF);
    chk("t1_idx0", 32'(grant_idx), 0);
    in_valid = 5'b00100;
    sb.push_back({4'd2, 8'hAA});
    ready_at_neg("t1_second", 5'b00100);
    cyc();
    chk("t1_idx2", 32'(grant_idx), 2);
    chk("t1_data2", 32'(out_data), 32'hAA);
    in_valid = '0;
    ready_at_neg("t1_idle", 5'b0);
    cyc();
    // ptr must now be 3: port 3 beats port 0.
    setd(0, 8'h01); setd(3, 8'h33); in_valid = 5'b01001;
    sb.push_back({4'd3, 8'h33});
    ready_at_neg("t1_ptr3", 5'b01000);
    cyc();
    in_valid = '0;
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    // Continuous full load rotates through every port.
    setd(0, 8'h10); setd(1, 8'h20); setd(2, 8'h80); setd(3, 8'h40); setd(4, 8'h50);
    in_valid = '1;
    for (int i = 0; i < 6; i++) begin
      sb.push_back({4'(i % REN), in_data[(i % REN)*PL +: PL]});
      ready_at_neg("t2_rot", 5'(1 << (i % REN)));
      cyc();
    end
    chk("t2_last_idx", 32'(grant_idx), 0);
    in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      ready_at_neg("t4_idle", 5'b0);
      cyc();
    end
    chk("t4_out_valid", 32'(out_valid), 0);
    chk("t4_idx_hold", 32'(grant_idx), 0);
    // Backpressure stall on port 3 (ptr=1).
    setd(3, 8'hFF); in_valid = 5'b01000; out_ready = 1'b0;
    sb.push_back({4'd3, 8'hFF});
    ready_at_neg("t3_grant", 5'b01000);
    cyc();
    setd(3, 8'hEE);
    for (int i = 0; i < 3; i++) begin
      ready_at_neg("t3_stall_ready", 5'b0);
      chk("t3_stall_valid", 32'(out_valid), 1);
      chk("t3_stall_data", 32'(out_data), 32'hFF);
      cyc();
    end
    in_valid = '0; out_ready = 1'b1;
    cyc();
    chk("t3_drop_valid", 32'(out_valid), 0);
    chk("t3_hold_data", 32'(out_data), 32'hFF);
    // Reset with a stalled packet in flight (ptr=4).
    setd(4, 8'h80); in_valid = 5'b10000; out_ready = 1'b0;
    ready_at_neg("t5_load", 5'b10000);
    cyc();
    chk("t5_inflight", 32'(out_data), 32'h80);
    setd(1, 8'h11); setd(4, 8'h44); in_valid = 5'b10010; rst = 1'b1;
    ready_at_neg("t5_rst_ready_a", 5'b0);
    cyc();
    chk("t5_rst_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    ready_at_neg("t5_rst_ready_b", 5'b0);
    cyc();
    rst = 1'b0;
    sb.push_back({4'd1, 8'h11});
    ready_at_neg("t5_port1_first", 5'b00010);
    cyc();
    in_valid = 5'b10000;
    sb.push_back({4'd4, 8'h44});
    ready_at_neg("t5_port4", 5'b10000);
    cyc();
    in_valid = '0;
`endif
    cyc(); cyc(); cyc();
    chk("sb_drain", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
